mem_arbiter: RTL and testbench

- Shares the single-port 1024-word unified memory between the core's instruction-fetch port and its load/store port.
- Sequences each access through a small FSM.
- Generates per-byte write enables and lane-shifted store data for byte, half and word stores.
- Extracts and sign- or zero-extends load data, and flags misaligned accesses.
- Sits between the multicycle core and the memory instance; it is the only driver of the memory's address, data_in, we and byte_enable inputs.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the unified-memory arbiter.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store enables/replication, load extraction
// with sign/zero extension, and alignment checking.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_in_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted      = mem_data_i >> {off_i, 3'b000};
        be_o         = 4'b0000;
        data_in_o    = 32'd0;
        rdata_o      = 32'd0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o      = 4'b0001 << off_i;
                data_in_o = {4{wdata_i[7:0]}};
                rdata_o   = uns_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                misaligned_o = off_i[0];
                be_o         = 4'b0011 << off_i;
                data_in_o    = {2{wdata_i[15:0]}};
                rdata_o      = uns_i ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                misaligned_o = (off_i != 2'b00);
                be_o         = 4'hF;
                data_in_o    = wdata_i;
                rdata_o      = mem_data_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for the single-port unified memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RESET_PRIO_D = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    output logic              mem_we,
    output logic [3:0]        mem_byte_enable,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              winner;
    logic [3:0]        be;
    logic [31:0]       din, rd_ext;
    logic              mis;

`ifdef MEM_ARB_RR_EN
    logic prio_q, prio_d;

    // Only a contested grant consults the priority bit.
    assign winner = (i_req && d_req) ? prio_q : d_req;
    assign prio_d = (state_q == IDLE && (i_req || d_req)) ? ~winner : prio_q;

    always_ff @(posedge clk) begin
        if (reset) prio_q <= RESET_PRIO_D[0];
        else       prio_q <= prio_d;
    end
`else
    assign winner = d_req ? PORT_D : PORT_I;
`endif

    mem_lane_align u_align (
        .off_i        (addr_q[1:0]),
        .size_i       (size_q),
        .uns_i        (uns_q),
        .wdata_i      (wdata_q),
        .mem_data_i   (mem_data_out),
        .be_o         (be),
        .data_in_o    (din),
        .rdata_o      (rd_ext),
        .misaligned_o (mis)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (i_req || d_req) begin
                state_d = SERVE;
                grant_d = winner;
                if (winner == PORT_D) begin
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    size_d  = d_size;
                    uns_d   = d_unsigned;
                end else begin
                    // Fetches are plain aligned word loads.
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    wdata_d = 32'd0;
                    size_d  = SZ_WORD;
                    uns_d   = 1'b0;
                end
            end
            SERVE: begin
                state_d = RESP;
                rdata_d = (we_q || mis) ? 32'd0 : rd_ext;
                err_d   = mis;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= PORT_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic serve, store_ok;
    assign serve    = (state_q == SERVE);
    assign store_ok = serve && we_q && !mis;

    assign mem_address     = serve ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we          = store_ok;
    assign mem_byte_enable = store_ok ? be : 4'b0000;
    assign mem_data_in     = store_ok ? din : 32'd0;

    assign i_ack   = (state_q == RESP) && (grant_q == PORT_I);
    assign d_ack   = (state_q == RESP) && (grant_q == PORT_D);
    assign i_rdata = i_ack ? rdata_q : 32'd0;
    assign i_err   = i_ack && err_q;
    assign d_rdata = d_ack ? rdata_q : 32'd0;
    assign d_err   = d_ack && err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-enabled memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_unsigned, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_we, busy;
    logic [3:0]  mem_byte_enable;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .RESET_PRIO_D(1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_we(mem_we), .mem_byte_enable(mem_byte_enable), .busy(busy)
    );

    // Memory model with a side preload port used only while the DUT is idle.
    logic [31:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    assign mem_data_out = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b]) mem[mem_address[11:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
    end

    int          we_cnt = 0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_din = '0;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;
    always @(negedge clk) if (mem_we) begin last_be <= mem_byte_enable; last_din <= mem_data_in; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output int lat, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        d_we = we; d_addr = addr; d_wdata = wd; d_size = sz; d_unsigned = uns; d_req = 1'b1;
        lat = 0; rd = 'x; err = 1'bx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_ack) begin rd = d_rdata; err = d_err; break; end
            lat++;
        end
        d_req = 1'b0;
    endtask

    task automatic run_i(input logic [31:0] addr, output int lat, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        i_addr = addr; i_req = 1'b1;
        lat = 0; rd = 'x; err = 1'bx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (i_ack) begin rd = i_rdata; err = i_err; break; end
            lat++;
        end
        i_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    initial begin
        int          lat, c0, cd, ci, n;
        logic [31:0] rd;
        logic        err;
        logic [3:0]  order;

        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_unsigned = 0;
        preload(10'h010, 32'hDEADBEEF);
        preload(10'h200, 32'h11223344);
        preload(10'h201, 32'h00005678);
        @(negedge clk);
        check("rst_ctrl", {23'd0, busy, i_ack, d_ack, i_err, d_err, mem_we, mem_byte_enable}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_din", mem_data_in, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Fetch
        c0 = we_cnt;
        run_i(32'h40, lat, rd, err);
        check("fetch_lat", lat, 2);
        check("fetch_rdata", rd, 32'hDEADBEEF);
        check("fetch_err", {31'd0, err}, 32'd0);
        check("fetch_nowe", we_cnt, c0);
        run_i(32'h42, lat, rd, err);
        check("fetch_mis_err", {31'd0, err}, 32'd1);
        check("fetch_mis_rdata", rd, 32'd0);

        // Byte store and loads
        run_d(1'b1, 32'h803, 32'h000000A5, 2'd0, 1'b0, lat, rd, err);
        check("sb_lat", lat, 2);
        check("sb_be", {28'd0, last_be}, 32'h8);
        check("sb_din", last_din, 32'hA5A5A5A5);
        check("sb_rdata", rd, 32'd0);
        run_d(1'b0, 32'h800, 32'd0, 2'd2, 1'b0, lat, rd, err);
        check("lw_after_sb", rd, 32'hA5223344);
        run_d(1'b0, 32'h803, 32'd0, 2'd0, 1'b0, lat, rd, err);
        check("lb_signed", rd, 32'hFFFFFFA5);
        run_d(1'b0, 32'h803, 32'd0, 2'd0, 1'b1, lat, rd, err);
        check("lbu", rd, 32'h000000A5);
        run_d(1'b0, 32'h801, 32'd0, 2'd0, 1'b0, lat, rd, err);
        check("lb_off1", rd, 32'h00000033);

        // Half store, loads, error cases
        run_d(1'b1, 32'h806, 32'h00001234, 2'd1, 1'b0, lat, rd, err);
        check("sh_be", {28'd0, last_be}, 32'hC);
        check("sh_din", last_din, 32'h12341234);
        run_d(1'b0, 32'h804, 32'd0, 2'd2, 1'b0, lat, rd, err);
        check("lw_after_sh", rd, 32'h12345678);
        run_d(1'b0, 32'h802, 32'd0, 2'd1, 1'b0, lat, rd, err);
        check("lh_signed_neg", rd, 32'hFFFFA522);
        run_d(1'b0, 32'h802, 32'd0, 2'd1, 1'b1, lat, rd, err);
        check("lhu", rd, 32'h0000A522);
        c0 = we_cnt;
        run_d(1'b0, 32'h805, 32'd0, 2'd1, 1'b0, lat, rd, err);
        check("lh_mis_lat", lat, 2);
        check("lh_mis_err", {31'd0, err}, 32'd1);
        check("lh_mis_rdata", rd, 32'd0);
        run_d(1'b1, 32'h805, 32'hFFFF, 2'd1, 1'b0, lat, rd, err);
        check("sh_mis_err", {31'd0, err}, 32'd1);
        run_d(1'b1, 32'h800, 32'hFFFFFFFF, 2'd3, 1'b0, lat, rd, err);
        check("sz3_err", {31'd0, err}, 32'd1);
        run_d(1'b1, 32'h802, 32'hFFFFFFFF, 2'd2, 1'b0, lat, rd, err);
        check("sw_mis_err", {31'd0, err}, 32'd1);
        check("err_nowrite", we_cnt, c0);
        run_d(1'b0, 32'h800, 32'd0, 2'd2, 1'b0, lat, rd, err);
        check("mem_intact", rd, 32'hA5223344);

        // Contention: data wins first after reset in either arbitration mode
        pulse_reset();
        d_we = 0; d_addr = 32'h800; d_size = 2'd2; d_unsigned = 0; i_addr = 32'h40;
        d_req = 1; i_req = 1; cd = -1; ci = -1;
        for (int k = 0; k < 12 && (ci < 0 || cd < 0); k++) begin
            @(negedge clk);
            if (d_ack) begin cd = k; d_req = 0; end
            if (i_ack) begin ci = k; i_req = 0; end
        end
        d_req = 0; i_req = 0;
        check("cont_d_cycle", cd, 2);
        check("cont_i_cycle", ci, 5);

        // Saturation: both held for four grants
        @(posedge clk); #1;
        d_req = 1; i_req = 1; order = '0; n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            @(negedge clk);
            if (d_ack || i_ack) begin order = {order[2:0], d_ack}; n++; end
        end
        d_req = 0; i_req = 0;
        check("sat_grants", n, 4);
`ifdef MEM_ARB_RR_EN
        check("sat_order_rr", {28'd0, order}, 32'hA);
`else
        check("sat_order_fixed", {28'd0, order}, 32'hF);
`endif

        // Reset during SERVE of a load; request re-served afterwards
        @(posedge clk); #1;
        d_we = 0; d_addr = 32'h804; d_size = 2'd2; d_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_serve", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {23'd0, busy, i_ack, d_ack, i_err, d_err, mem_we, mem_byte_enable}, 32'd0);
        check("rst_mid_addr", mem_address | mem_data_in | d_rdata, 32'd0);
        reset = 1'b0;
        lat = 0; rd = 'x;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_ack) begin rd = d_rdata; break; end
            lat++;
        end
        d_req = 0;
        check("rst_reserve_lat", lat, 1);
        check("rst_reserve_rdata", rd, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
